// File: rtl/ram_burst_reader_if.sv
// Bus bundle for the RAM burst reader: burst control, RAM read port and
// the output word stream.
//
// Stream handshake: a word moves from the reader to the consumer at a rising
// edge where out_valid and out_ready are both high. out_valid never depends
// on out_ready in the same cycle, and a word stays stable at the FIFO head
// until it is taken.
interface ram_burst_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_dataout;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // Reader side
  modport master (
    input  start, base_addr, length, mem_dataout, out_ready,
    output busy, done, mem_address, mem_read, mem_write, out_data, out_valid
  );

  // Environment side: burst requester, RAM and stream consumer
  modport slave (
    output start, base_addr, length, mem_dataout, out_ready,
    input  busy, done, mem_address, mem_read, mem_write, out_data, out_valid
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst reader: fetches a run of consecutive RAM words (one-cycle read
// latency) into a small FIFO and streams them out with valid/ready.
// Reads are throttled so that buffered words plus reads still in flight
// never exceed the FIFO depth, so the FIFO cannot overflow.
module ram_burst_reader #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                RST,
  ram_burst_reader_if.master  bus,
  output logic [1:0]          o_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_mem_read;    // read being issued this cycle
  logic              r_pend;        // read issued last cycle, data on mem_dataout now
  logic [ADDR_W-1:0] r_mem_address;
  logic [15:0]       r_remaining;   // reads not yet scheduled
  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [CNT_W:0]    w_occ_nxt;
  logic              w_issue;

  assign w_push = r_pend;
  assign w_pop  = (r_count != '0) && bus.out_ready;

  // Occupancy after this edge, accounting for the push/pop happening now
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Next cycle's read is allowed if buffered words plus the read that will
  // then be in flight leave room in the FIFO.
  assign w_occ_nxt = {1'b0, w_count_nxt} + {{CNT_W{1'b0}}, r_mem_read};
  assign w_issue   = (r_state == S_FETCH) && (r_remaining != 16'd0) &&
                     (w_occ_nxt < DEPTH_L);

  // Control FSM, read issue, FIFO pointers and registered outputs
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_mem_read    <= 1'b0;
      r_pend        <= 1'b0;
      r_mem_address <= '0;
      r_remaining   <= 16'd0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_done  <= 1'b0;
      r_pend  <= r_mem_read;
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case (r_state)
        S_IDLE: begin
          r_mem_read <= 1'b0;
          if (bus.start) begin
            if (bus.length != 16'd0) begin
              // First read goes out in the first busy cycle
              r_state       <= S_FETCH;
              r_busy        <= 1'b1;
              r_mem_read    <= 1'b1;
              r_mem_address <= bus.base_addr;
              r_remaining   <= bus.length - 16'd1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            r_mem_read    <= 1'b1;
            r_mem_address <= r_mem_address + ADDR_W'(1);
            r_remaining   <= r_remaining - 16'd1;
          end else begin
            r_mem_read <= 1'b0;
          end
          if (r_remaining == 16'd0) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_mem_read <= 1'b0;
          if (!r_pend && (w_count_nxt == '0)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_mem_read <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage: captures the word returned for last cycle's read
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= bus.mem_dataout;
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = 1'b0;
  assign bus.mem_address = r_mem_address;
  assign bus.out_valid   = (r_count != '0);
  assign bus.out_data    = (r_count != '0) ? r_fifo[r_rd_ptr] : '0;
  assign o_state         = r_state;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: RAM model with one-cycle read latency, a
// negedge monitor, directed bursts and randomized bursts checked against
// a word-list model (word i of a burst = RAM[base+i]).
module tb_ram_burst_reader;

  logic        clk;
  logic        RST;
  logic [1:0]  dbg_state;
  logic [15:0] ram_key;

  ram_burst_reader_if #(.ADDR_W(16), .DATA_W(16)) bus_if ();

  ram_burst_reader #(.ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .RST     (RST),
    .bus     (bus_if),
    .o_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: mem[a] = a + key (key = 0x100 for directed tests)
  function automatic logic [15:0] ram_word(input logic [15:0] a);
    return a + ram_key;
  endfunction

  // Synchronous RAM, one-cycle read latency
  initial bus_if.mem_dataout = 16'h0;
  always @(posedge clk) if (bus_if.mem_read) bus_if.mem_dataout <= ram_word(bus_if.mem_address);

  // Monitor
  int          cyc = 0;
  int          n_reads, n_done, n_busy, done_cyc, accept_cyc;
  logic [15:0] got_q[$];
  logic [15:0] addr_q[$];
  int          read_cyc_q[$];
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!RST) begin
      if (bus_if.mem_read) begin
        n_reads++;
        addr_q.push_back(bus_if.mem_address);
        read_cyc_q.push_back(cyc);
      end
      if (bus_if.done) begin n_done++; done_cyc = cyc; end
      if (bus_if.busy) n_busy++;
      if (bus_if.out_valid && bus_if.out_ready) got_q.push_back(bus_if.out_data);
    end
  end

  // Scoreboard counters
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_reads = 0; n_done = 0; n_busy = 0; done_cyc = 0;
    got_q.delete(); addr_q.delete(); read_cyc_q.delete();
  endtask

  task automatic start_burst(input logic [15:0] base, input logic [15:0] len);
    clear_mon();
    bus_if.start     = 1'b1;
    bus_if.base_addr = base;
    bus_if.length    = len;
    step();
    bus_if.start     = 1'b0;
    accept_cyc       = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit rnd);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      if (rnd) bus_if.out_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    check({tag, "_done_seen"}, 32'(n_done != 0), 32'd1);
    bus_if.out_ready = 1'b1;
    repeat (4) step();
  endtask

  // Model: a burst delivers RAM[base], RAM[base+1], ... exactly len words
  task automatic check_stream(input string tag, input logic [15:0] base, input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(ram_word(base + 16'(i)));
    check({tag, "_word_count"}, 32'(got_q.size()), 32'(len));
    for (int i = 0; i < len && i < got_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      32'(bus_if.busy),        32'd0);
    check({tag, "_done"},      32'(bus_if.done),        32'd0);
    check({tag, "_mem_read"},  32'(bus_if.mem_read),    32'd0);
    check({tag, "_mem_write"}, 32'(bus_if.mem_write),   32'd0);
    check({tag, "_mem_addr"},  32'(bus_if.mem_address), 32'd0);
    check({tag, "_out_valid"}, 32'(bus_if.out_valid),   32'd0);
    check({tag, "_out_data"},  32'(bus_if.out_data),    32'd0);
  endtask

  initial begin
    int k;
    logic [15:0] rb;
    int rl;
    ram_key          = 16'h0100;
    RST              = 1'b1;
    bus_if.start     = 1'b0;
    bus_if.base_addr = 16'h0;
    bus_if.length    = 16'h0;
    bus_if.out_ready = 1'b0;
    clear_mon();
    repeat (3) step();
    check_reset_outputs("reset");
    RST = 1'b0;
    step();

    // Basic burst, consumer always ready
    bus_if.out_ready = 1'b1;
    start_burst(16'd10, 16'd5);
    check("b5_busy_after_start", 32'(bus_if.busy), 32'd1);
    wait_done("b5", 100, 1'b0);
    check_stream("b5", 16'd10, 5);
    check("b5_reads", 32'(n_reads), 32'd5);
    if (read_cyc_q.size() == 5)
      check("b5_read_span", 32'(read_cyc_q[4] - read_cyc_q[0]), 32'd4);
    else
      check("b5_read_span_count", 32'(read_cyc_q.size()), 32'd5);
    check("b5_done_count", 32'(n_done), 32'd1);
    check("b5_busy_cycles", 32'(n_busy), 32'(done_cyc - (accept_cyc + 1)));

    // Back-pressure: only FIFO_DEPTH reads may be outstanding
    bus_if.out_ready = 1'b0;
    start_burst(16'd10, 16'd12);
    repeat (10) step();
    check("bp_reads_stalled", 32'(n_reads), 32'd4);
    check("bp_mem_read_low", 32'(bus_if.mem_read), 32'd0);
    check("bp_out_valid", 32'(bus_if.out_valid), 32'd1);
    check("bp_head_word", 32'(bus_if.out_data), 32'(ram_word(16'd10)));
    bus_if.out_ready = 1'b1;
    wait_done("bp", 200, 1'b0);
    check_stream("bp", 16'd10, 12);
    check("bp_reads", 32'(n_reads), 32'd12);
    check("bp_done_count", 32'(n_done), 32'd1);

    // Zero-length request
    start_burst(16'd33, 16'd0);
    check("z_done_next", 32'(bus_if.done), 32'd1);
    check("z_busy", 32'(bus_if.busy), 32'd0);
    repeat (3) step();
    check("z_reads", 32'(n_reads), 32'd0);
    check("z_done_count", 32'(n_done), 32'd1);
    check("z_busy_count", 32'(n_busy), 32'd0);

    // Address wrap
    start_burst(16'hFFFE, 16'd3);
    wait_done("wrap", 100, 1'b0);
    check("wrap_addr_count", 32'(addr_q.size()), 32'd3);
    if (addr_q.size() == 3) begin
      check("wrap_addr0", 32'(addr_q[0]), 32'h0000FFFE);
      check("wrap_addr1", 32'(addr_q[1]), 32'h0000FFFF);
      check("wrap_addr2", 32'(addr_q[2]), 32'h00000000);
    end
    check_stream("wrap", 16'hFFFE, 3);

    // Reset mid-burst
    start_burst(16'd20, 16'd8);
    k = 0;
    while (got_q.size() < 3 && k < 50) begin step(); k++; end
    check("rst_three_words", 32'(got_q.size() >= 3), 32'd1);
    RST = 1'b1;
    step();
    check_reset_outputs("rst_mid");
    check("rst_no_done", 32'(n_done), 32'd0);
    RST = 1'b0;
    clear_mon();
    repeat (3) step();
    check("rst_no_stale_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_no_stale_words", 32'(got_q.size()), 32'd0);
    start_burst(16'd0, 16'd2);
    wait_done("rst_fresh", 100, 1'b0);
    check_stream("rst_fresh", 16'd0, 2);
    check("rst_fresh_done", 32'(n_done), 32'd1);

    // Start during an active burst is ignored
    start_burst(16'd50, 16'd6);
    step();
    bus_if.start     = 1'b1;
    bus_if.base_addr = 16'd999;
    bus_if.length    = 16'd3;
    step();
    bus_if.start     = 1'b0;
    wait_done("ign", 300, 1'b1);
    check_stream("ign", 16'd50, 6);
    check("ign_reads", 32'(n_reads), 32'd6);
    check("ign_done_count", 32'(n_done), 32'd1);

    // Randomized bursts with random back-pressure and RAM contents
    for (int t = 0; t < 8; t++) begin
      ram_key = 16'($urandom);
      rb      = 16'($urandom);
      rl      = $urandom_range(1, 20);
      start_burst(rb, 16'(rl));
      wait_done($sformatf("rnd%0d", t), 40 * rl + 50, 1'b1);
      check_stream($sformatf("rnd%0d", t), rb, rl);
      check($sformatf("rnd%0d_reads", t), 32'(n_reads), 32'(rl));
      check($sformatf("rnd%0d_done_count", t), 32'(n_done), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, RAM/stream data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle burst request, sampled in IDLE only.
REQ-007 SHALL have port base_addr  input  ADDR_W  first RAM word address, latched on accepted start.
REQ-008 SHALL have port length  input  16  word count, latched on accepted start.
REQ-009 SHALL have port busy  output  1  high from the cycle after accepted start until done pulse.
REQ-010 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-011 SHALL have port mem_address  output  ADDR_W  RAM read address.
REQ-012 SHALL have port mem_read  output  1  RAM read strobe.
REQ-013 SHALL have port mem_write  output  1  RAM write strobe, constant 0.
REQ-014 SHALL have port mem_dataout  input  DATA_W  RAM read data.
REQ-015 SHALL have port out_data  output  DATA_W  stream word, FIFO head.
REQ-016 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-017 SHALL have port out_ready  input  1  downstream accept; transfer when out_valid and out_ready both high at a rising edge.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN.
REQ-019 IDLE + start + length!=0 SHALL latch base_addr/length, go to FETCH, assert busy next cycle.
REQ-020 IDLE + start + length==0 SHALL pulse done next cycle, issue no reads, stay IDLE, busy stays low.
REQ-021 start while not IDLE SHALL be ignored.
REQ-022 In FETCH, a read SHALL be issued (mem_read=1, mem_address=next address) in a cycle only when remaining>0 and (FIFO occupancy + in-flight reads) < FIFO_DEPTH.
REQ-023 Reads SHALL use addresses base_addr, base_addr+1, ... in order, modulo 2^ADDR_W (wrap 0xFFFF -> 0x0000).
REQ-024 Read latency SHALL be fixed at one cycle: data issued in cycle k is captured from mem_dataout at the rising edge ending cycle k+1 and pushed into the FIFO.
REQ-025 Back-to-back reads SHALL be issued every cycle while REQ-022 holds (throughput one word/cycle with out_ready high).
REQ-026 When mem_read=0, mem_address SHALL hold its last value.
REQ-027 After the last read issues, state SHALL go to DRAIN.
REQ-028 DRAIN SHALL exit when no read is in flight and FIFO is empty: done pulses for one cycle, busy drops same cycle, state returns to IDLE.
REQ-029 Simultaneous FIFO push and pop SHALL leave occupancy unchanged; word order SHALL be preserved.
REQ-030 FIFO SHALL never overflow or underflow; out_data SHALL be don't-care when out_valid=0.
REQ-031 out_valid SHALL not depend combinationally on out_ready.

Reset
REQ-032 RST high at a rising edge SHALL force IDLE, FIFO empty, in-flight reads discarded, remaining count 0.
REQ-033 After reset: busy=0, done=0, mem_read=0, mem_write=0, mem_address=0, out_valid=0, out_data=0.
REQ-034 Reset mid-burst SHALL abort without done pulse; captured data of the aborting read SHALL be dropped.

Verification
REQ-035 RAM preloaded mem[i]=i+0x100, start base=10 length=5, out_ready=1 -> stream 0x10A..0x10E in order, 5 reads on consecutive cycles, done once, busy high throughout.
REQ-036 Same burst, length=12, out_ready=0 -> exactly 4 reads issued then mem_read=0; after out_ready=1, remaining 8 words follow, total 12, no loss or duplication.
REQ-037 start with length=0 -> done pulses next cycle, mem_read never asserted, busy stays 0.
REQ-038 base=0xFFFE length=3 -> mem_address sequence 0xFFFE, 0xFFFF, 0x0000.
REQ-039 RST asserted after 3 of 8 words delivered -> next cycle all outputs at reset values, no done; fresh start base=0 length=2 completes normally.
REQ-040 start pulsed during active burst -> ignored; word count and done count match first burst only.
